// File: rtl/runner_pipe_pkg.sv
// rtl/runner_pipe_pkg.sv - shared types and width helper for the elastic delay pipe
package runner_pipe_pkg;

    typedef logic valid_t;
    typedef logic ready_t;

    // Bits needed to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < (depth + 1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/runner_elastic_pipe_if.sv
// rtl/runner_elastic_pipe_if.sv - handshake, flush and occupancy bundle of the elastic pipe
interface runner_elastic_pipe_if
    import runner_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic             flush;
    valid_t           in_valid;
    ready_t           in_ready;
    logic [WIDTH-1:0] in_data;
    valid_t           out_valid;
    ready_t           out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/runner_pipe_stage.sv
// rtl/runner_pipe_stage.sv - one valid+data register of the elastic pipe
module runner_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    // Data is only captured alongside a valid item; bubbles leave stale data in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else if (flush_i) begin
            v_q <= 1'b0;
        end else if (load_i) begin
            v_q <= up_valid_i;
            if (up_valid_i) begin
                d_q <= up_data_i;
            end
        end
    end

    assign valid_o = v_q;
    assign data_o  = d_q;

endmodule

// File: rtl/runner_elastic_pipe.sv
// rtl/runner_elastic_pipe.sv - DEPTH-stage elastic delay line with collapsing bubbles and flush
module runner_elastic_pipe
    import runner_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    runner_elastic_pipe_if.slave  pipe
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] up_v;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A stage may load when it is empty or its item moves on this cycle.
    always_comb begin
        load = '0;
        load[DEPTH-1] = ~v[DEPTH-1] | pipe.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            load[i] = ~v[i] | load[i+1];
        end
    end

    assign up_v[0] = pipe.in_valid;
    assign up_d[0] = pipe.in_data;

    for (genvar g = 1; g < DEPTH; g++) begin : g_link
        assign up_v[g] = v[g-1];
        assign up_d[g] = d[g-1];
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        runner_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (pipe.flush),
            .load_i     (load[g]),
            .up_valid_i (up_v[g]),
            .up_data_i  (up_d[g]),
            .valid_o    (v[g]),
            .data_o     (d[g])
        );
    end

    // Occupancy is the popcount of the valid bits the stages will hold after this edge.
    always_comb begin
        v_d     = '0;
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_d[i]  = pipe.flush ? 1'b0 : (load[i] ? up_v[i] : v[i]);
            count_d = count_d + CNT_W'(v_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pipe.in_ready  = load[0] & ~pipe.flush;
    assign pipe.out_valid = v[DEPTH-1] & ~pipe.flush;
    assign pipe.out_data  = d[DEPTH-1];
    assign pipe.count     = count_q;

endmodule

// File: tb/tb_runner_elastic_pipe.sv
// tb/tb_runner_elastic_pipe.sv - randomized self-checking bench for runner_elastic_pipe
module tb_runner_elastic_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    runner_elastic_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    runner_elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .pipe  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_fail;

    // Reference: in-flight items in order (oldest first) with their stage position.
    int q_d[$];
    int q_p[$];
    int np[$];
    bit popped;
    int last_out;
    bit exp_in_ready;

    logic [31:0] obs_in_ready, obs_out_valid, obs_out_data, obs_count;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Each item advances one position unless blocked by the item ahead; the oldest leaves when accepted.
    function automatic void predict(input bit ordy);
        int lim;
        int cand;
        np = {};
        popped = 1'b0;
        lim = DEPTH + 1;
        for (int k = 0; k < q_p.size(); k++) begin
            if (k == 0 && q_p[0] == DEPTH - 1) begin
                cand = ordy ? DEPTH : DEPTH - 1;
                popped = ordy;
            end else begin
                cand = q_p[k] + 1;
                if (cand > lim - 1) cand = lim - 1;
                if (cand > DEPTH - 1) cand = DEPTH - 1;
            end
            np.push_back(cand);
            lim = cand;
        end
    endfunction

    task automatic cycle(input bit fl, input bit iv, input logic [7:0] id, input bit ordy);
        bit exp_ov;
        @(negedge clk);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        predict(ordy);
        exp_in_ready = !fl && (q_p.size() == 0 || np[np.size()-1] > 0);
        exp_ov       = !fl && q_p.size() > 0 && q_p[0] == DEPTH - 1;
        obs_in_ready  = 32'(bus.in_ready);
        obs_out_valid = 32'(bus.out_valid);
        obs_out_data  = 32'(bus.out_data);
        obs_count     = 32'(bus.count);
        expect_eq("in_ready", obs_in_ready, 32'(exp_in_ready));
        expect_eq("out_valid", obs_out_valid, 32'(exp_ov));
        expect_eq("out_data", obs_out_data, 32'(last_out));
        expect_eq("count", obs_count, 32'(q_p.size()));
        @(posedge clk);
        if (fl) begin
            q_d = {};
            q_p = {};
        end else begin
            for (int k = 0; k < q_p.size(); k++) begin
                if (np[k] == DEPTH - 1 && q_p[k] != DEPTH - 1) last_out = q_d[k];
                q_p[k] = np[k];
            end
            if (popped) begin
                void'(q_d.pop_front());
                void'(q_p.pop_front());
            end
            if (iv && exp_in_ready) begin
                q_d.push_back(int'(id));
                q_p.push_back(0);
                if (DEPTH == 1) last_out = int'(id);
            end
        end
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear immediately.
    task automatic do_reset();
        #2;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        expect_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        expect_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        expect_eq("rst_count", 32'(bus.count), 32'd0);
        expect_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        q_d = {};
        q_p = {};
        last_out = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, ordy);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        last_out = 0;
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        do_reset();

        // Streaming at full rate
        cycle(0, 1, 8'h11, 1);
        cycle(0, 1, 8'h22, 1);
        cycle(0, 1, 8'h33, 1);
        idle(2, 1);
        expect_eq("stream_first", obs_out_data, 32'h11);
        expect_eq("stream_first_v", obs_out_valid, 32'd1);
        idle(4, 1);

        // Backpressure until full, then simultaneous pop and push
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'hA0 + 8'(i), 0);
        cycle(0, 1, 8'hA4, 0);
        expect_eq("bp_full_ready", obs_in_ready, 32'd0);
        expect_eq("bp_full_count", obs_count, 32'd4);
        cycle(0, 1, 8'hA4, 1);
        expect_eq("bp_pushpop_ready", obs_in_ready, 32'd1);
        expect_eq("bp_pushpop_data", obs_out_data, 32'hA0);
        idle(1, 0);
        expect_eq("bp_count_after", obs_count, 32'd4);
        idle(6, 1);

        // Bubble collapse while stalled
        cycle(0, 1, 8'h55, 0);
        idle(2, 0);
        cycle(0, 1, 8'h66, 0);
        idle(2, 0);
        expect_eq("bubble_count", obs_count, 32'd2);
        idle(1, 1);
        expect_eq("bubble_out0", obs_out_data, 32'h55);
        idle(1, 1);
        expect_eq("bubble_out1", obs_out_data, 32'h66);
        idle(4, 1);

        // Flush with a live offer
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'hC0 + 8'(i), 0);
        cycle(1, 1, 8'h77, 0);
        expect_eq("flush_in_ready", obs_in_ready, 32'd0);
        idle(1, 1);
        expect_eq("flush_count", obs_count, 32'd0);
        idle(6, 1);

        // Reset mid-stream, then latency of a fresh item
        for (int i = 1; i <= 5; i++) cycle(0, 1, 8'(i), 1'(i % 2));
        do_reset();
        cycle(0, 1, 8'hF0, 1);
        idle(3, 1);
        expect_eq("lat_not_yet", obs_out_valid, 32'd0);
        idle(1, 1);
        expect_eq("lat_valid", obs_out_valid, 32'd1);
        expect_eq("lat_data", obs_out_data, 32'hF0);
        idle(3, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 31) == 0), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b1);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
